// File: rtl/alu_pkg.sv
// Shared widths, opcode constants and types for the ALU issue path.
package alu_pkg;

  localparam int OPW  = 2;
  localparam int SELW = 3;
  localparam int RESW = 5;
  localparam int CMDW = SELW + 2 * OPW;

  localparam logic [SELW-1:0] OP_ADD = 3'd0;
  localparam logic [SELW-1:0] OP_SUB = 3'd1;
  localparam logic [SELW-1:0] OP_MUL = 3'd2;
  localparam logic [SELW-1:0] OP_POW = 3'd3;
  localparam logic [SELW-1:0] OP_AND = 3'd4;
  localparam logic [SELW-1:0] OP_OR  = 3'd5;
  localparam logic [SELW-1:0] OP_XOR = 3'd6;
  localparam logic [SELW-1:0] OP_NOR = 3'd7;

  typedef struct packed {
    logic [SELW-1:0] sel;
    logic [OPW-1:0]  a;
    logic [OPW-1:0]  b;
  } cmd_t;

  typedef enum logic {
    RES_EMPTY = 1'b0,
    RES_FULL  = 1'b1
  } res_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// In-order command FIFO with wrap-around pointers and synchronous flush.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [CMDW-1:0]          din,
  input  logic                     pop,
  output logic [CMDW-1:0]          dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CMDW-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately unreset; count gates every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_issue.sv
// Queues ALU commands, presents the head to an external combinational ALU and holds its result.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OPW-1:0]          cmd_a,
  input  logic [OPW-1:0]          cmd_b,
  input  logic [SELW-1:0]         cmd_sel,
  output logic [OPW-1:0]          alu_a,
  output logic [OPW-1:0]          alu_b,
  output logic [SELW-1:0]         alu_sel,
  input  logic [RESW-1:0]         alu_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [RESW-1:0]         res_data,
  output logic [SELW-1:0]         res_sel,
  output logic [$clog2(DEPTH):0]  count
);

  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic [CMDW-1:0] head;
  cmd_t            head_cmd;
  res_state_t      state;
  res_state_t      state_next;

  // cmd_ready depends only on occupancy, never on res_ready.
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = !fifo_empty && ((state == RES_EMPTY) || res_ready);
  assign head_cmd  = cmd_t'(head);

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .din   ({cmd_sel, cmd_a, cmd_b}),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign alu_a   = fifo_empty ? '0 : head_cmd.a;
  assign alu_b   = fifo_empty ? '0 : head_cmd.b;
  assign alu_sel = fifo_empty ? '0 : head_cmd.sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RES_EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    state_next = state;
    if (flush)                                state_next = RES_EMPTY;
    else if (pop)                             state_next = RES_FULL;
    else if ((state == RES_FULL) && res_ready) state_next = RES_EMPTY;
  end

  assign res_valid = (state == RES_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
      res_sel  <= '0;
    end else if (flush) begin
      res_data <= '0;
      res_sel  <= '0;
    end else if (pop) begin
      res_data <= alu_out;
      res_sel  <= alu_sel;
    end
  end

endmodule
